// File: rtl/mem_bus_arbiter.sv
// Two-port memory bus arbiter: CPU and DMA requesters share one SRAM bus.
// A grant latches the winner's direction, address and write data. A
// fixed-length wait-state access follows, then a one-cycle acknowledge.
// Ties are broken round-robin against the last winner.
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   IDLE   | bus free; any request is granted at the next edge
//   ACCESS | mem_cs high; counter runs down WAIT_STATES extra cycles
//   DONE   | access finished; winner's ack pulses; back to IDLE next edge
module mem_bus_arbiter #(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 16,
  parameter int WAIT_STATES = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_gnt,
  output logic                  cpu_ack,
  input  logic                  dma_req,
  input  logic                  dma_we,
  input  logic [ADDR_WIDTH-1:0] dma_addr,
  input  logic [DATA_WIDTH-1:0] dma_wdata,
  output logic                  dma_gnt,
  output logic                  dma_ack,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [3:0] count;
  logic       last_grant;  // 1 = DMA won most recently
  logic       owner;       // 1 = DMA owns the current access
  logic       lat_we;
  logic       grant_any;
  logic       grant_dma;

  // Next-state decode, winner selection and bus/handshake outputs
  always_comb begin
    state_next = state;
    grant_any  = 1'b0;
    grant_dma  = 1'b0;
    mem_cs     = 1'b0;
    mem_we     = 1'b0;
    cpu_gnt    = 1'b0;
    dma_gnt    = 1'b0;
    cpu_ack    = 1'b0;
    dma_ack    = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_req || dma_req) begin
          grant_any  = 1'b1;
          // DMA wins alone, or on a tie when the CPU had the last grant
          grant_dma  = dma_req && (!cpu_req || !last_grant);
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        mem_cs  = 1'b1;
        mem_we  = lat_we;
        cpu_gnt = !owner;
        dma_gnt = owner;
        if (count == 4'd0) state_next = DONE;
      end
      DONE: begin
        cpu_gnt    = !owner;
        dma_gnt    = owner;
        cpu_ack    = !owner;
        dma_ack    = owner;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Grant latches, wait-state counter and read-data capture
  always_ff @(posedge clock) begin
    if (reset) begin
      count      <= 4'd0;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      lat_we     <= 1'b0;
      rdata      <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      if (grant_any) begin
        owner      <= grant_dma;
        last_grant <= grant_dma;
        lat_we     <= grant_dma ? dma_we    : cpu_we;
        mem_addr   <= grant_dma ? dma_addr  : cpu_addr;
        mem_wdata  <= grant_dma ? dma_wdata : cpu_wdata;
        count      <= 4'(WAIT_STATES);
      end
      if (state == ACCESS) begin
        if (count != 4'd0) count <= count - 4'd1;
        else if (!lat_we)  rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: a timestamp-based transaction
// model predicts every output each cycle; directed scenarios add literal checks.
module tb_mem_bus_arbiter;
  localparam int DW = 16;
  localparam int AW = 16;
  localparam int WS = 2;

  logic          clock;
  logic          reset;
  logic          cpu_req, cpu_we, cpu_gnt, cpu_ack;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          dma_req, dma_we, dma_gnt, dma_ack;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata;
  logic [DW-1:0] rdata;
  logic          mem_cs, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  mem_bus_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WAIT_STATES(WS)) dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_ack(cpu_ack),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_ack(dma_ack),
    .rdata(rdata), .mem_cs(mem_cs), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // SRAM model with a bench-side preload port
  logic [DW-1:0] mem [0:65535];
  logic          pl_en;
  logic [AW-1:0] pl_addr;
  logic [DW-1:0] pl_data;
  assign mem_rdata = mem[mem_addr];

  // Memory write port: preload, or DUT write while selected
  always @(posedge clock) begin
    if (pl_en)                mem[pl_addr]  <= pl_data;
    else if (mem_cs && mem_we) mem[mem_addr] <= mem_wdata;
  end

  // Transaction model: an access granted at edge e0 occupies edges e0..e0+WS+2
  int            cyc = 0;
  bit            mv = 0;
  bit            m_busy = 0, m_own = 0, m_last = 1, m_we = 0;
  int            m_e0 = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0, m_rdata = '0;
  wire           tie_dma = dma_req && (!cpu_req || !m_last);

  // Model update on every rising edge
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (reset) begin
      mv <= 1; m_busy <= 0; m_last <= 1; m_own <= 0; m_we <= 0;
      m_rdata <= '0; m_addr <= '0; m_wdata <= '0;
    end else if (m_busy) begin
      if (cyc == m_e0 + WS + 1 && !m_we) m_rdata <= mem[m_addr];
      if (cyc == m_e0 + WS + 2) m_busy <= 0;
    end else if (cpu_req || dma_req) begin
      m_busy  <= 1;
      m_e0    <= cyc;
      m_own   <= tie_dma;
      m_last  <= tie_dma;
      m_we    <= tie_dma ? dma_we : cpu_we;
      m_addr  <= tie_dma ? dma_addr : cpu_addr;
      m_wdata <= tie_dma ? dma_wdata : cpu_wdata;
    end
  end

  int n_cmp = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_cycle();
    int k;
    bit e_cs, e_done;
    k      = cyc - 1 - m_e0;
    e_cs   = m_busy && (k <= WS);
    e_done = m_busy && (k == WS + 1);
    chk("mem_cs",    mem_cs,    e_cs);
    chk("mem_we",    mem_we,    e_cs && m_we);
    chk("cpu_gnt",   cpu_gnt,   m_busy && !m_own);
    chk("dma_gnt",   dma_gnt,   m_busy && m_own);
    chk("cpu_ack",   cpu_ack,   e_done && !m_own);
    chk("dma_ack",   dma_ack,   e_done && m_own);
    chk("mem_addr",  mem_addr,  m_addr);
    chk("mem_wdata", mem_wdata, m_wdata);
    chk("rdata",     rdata,     m_rdata);
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
    if (mv) check_cycle();
  endtask

  // Issue one request, hold it until the matching ack, then drop it
  task automatic run_xfer(input bit dma, input bit we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] data, output int cs_cnt, output int ack_at);
    cs_cnt = 0;
    ack_at = -1;
    if (dma) begin dma_req = 1; dma_we = we; dma_addr = addr; dma_wdata = data; end
    else     begin cpu_req = 1; cpu_we = we; cpu_addr = addr; cpu_wdata = data; end
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (mem_cs) cs_cnt++;
      if (dma ? dma_ack : cpu_ack) begin ack_at = i; break; end
    end
    cpu_req = 0;
    dma_req = 0;
  endtask

  int cs, ack_at, ng, n_ack, overlap, nw, acks;
  int order [4];
  int ws_start [2], ws_last [2], wadr [2];
  bit prev_c, prev_d, prev_cs;

  initial begin
    reset = 1; pl_en = 0; pl_addr = '0; pl_data = '0;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;

    // Preload under reset
    pl_en = 1; pl_addr = 16'h1234; pl_data = 16'hBEEF; tick();
    pl_addr = 16'h0001; pl_data = 16'h1111; tick();
    pl_addr = 16'h0002; pl_data = 16'h2222; tick();
    pl_en = 0; tick();
    chk("rst_rdata", rdata, 16'h0000);
    chk("rst_mem_cs", mem_cs, 1'b0);
    chk("rst_mem_addr", mem_addr, 16'h0000);
    reset = 0; tick();

    // Single CPU read
    run_xfer(0, 0, 16'h1234, 16'h0000, cs, ack_at);
    chk("rd_cs_cycles", cs, WS + 1);
    chk("rd_ack_edges_after_grant", ack_at - 1, 3);
    tick();
    chk("rd_rdata", rdata, 16'hBEEF);

    // Single DMA write
    run_xfer(1, 1, 16'h00F0, 16'h5A5A, cs, ack_at);
    chk("wr_cs_cycles", cs, WS + 1);
    chk("wr_ack_edges_after_grant", ack_at - 1, 3);
    tick();
    chk("wr_mem_content", mem[16'h00F0], 16'h5A5A);
    chk("wr_rdata_unchanged", rdata, 16'hBEEF);

    // Simultaneous requests after reset: CPU, DMA, CPU, DMA
    reset = 1; tick(); reset = 0;
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0001;
    dma_req = 1; dma_we = 0; dma_addr = 16'h0002;
    ng = 0; n_ack = 0; overlap = 0; prev_c = 0; prev_d = 0;
    for (int i = 0; i < 4; i++) order[i] = -1;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (cpu_gnt && !prev_c) begin if (ng < 4) order[ng] = 0; ng++; end
      if (dma_gnt && !prev_d) begin if (ng < 4) order[ng] = 1; ng++; end
      if (cpu_gnt && dma_gnt) overlap++;
      prev_c = cpu_gnt; prev_d = dma_gnt;
      if (cpu_ack || dma_ack) n_ack++;
      if (ng >= 4 && (cpu_ack || dma_ack)) break;
    end
    cpu_req = 0; dma_req = 0;
    chk("tie_grants", ng, 4);
    chk("tie_order0", order[0], 0);
    chk("tie_order1", order[1], 1);
    chk("tie_order2", order[2], 0);
    chk("tie_order3", order[3], 1);
    chk("tie_acks", n_ack, 4);
    chk("tie_gnt_overlap", overlap, 0);
    tick();

    // Back-to-back CPU reads
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0001;
    nw = 0; acks = 0; prev_cs = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (mem_cs && !prev_cs) begin
        if (nw < 2) begin ws_start[nw] = i; wadr[nw] = mem_addr; end
        nw++;
      end
      if (mem_cs && nw >= 1 && nw <= 2) ws_last[nw-1] = i;
      prev_cs = mem_cs;
      if (cpu_ack) begin
        acks++;
        cpu_addr = 16'h0002;
        if (acks == 2) break;
      end
    end
    cpu_req = 0;
    chk("b2b_windows", nw, 2);
    chk("b2b_gap", ws_start[1] - ws_last[0] - 1, 2);
    chk("b2b_addr0", wadr[0], 16'h0001);
    chk("b2b_addr1", wadr[1], 16'h0002);
    tick();
    chk("b2b_rdata", rdata, 16'h2222);

    // Reset during the second ACCESS cycle
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h1234;
    tick(); tick();
    chk("mid_cs_before_reset", mem_cs, 1'b1);
    reset = 1; tick();
    chk("mid_rst_cs", mem_cs, 1'b0);
    chk("mid_rst_gnt", {cpu_gnt, dma_gnt}, 2'b00);
    chk("mid_rst_ack", {cpu_ack, dma_ack}, 2'b00);
    chk("mid_rst_rdata", rdata, 16'h0000);
    reset = 0; cpu_req = 0;
    acks = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (cpu_ack || dma_ack) acks++;
    end
    chk("mid_rst_no_ack", acks, 0);
    cpu_req = 1; dma_req = 1;
    tick();
    chk("post_rst_tie_cpu_gnt", cpu_gnt, 1'b1);
    chk("post_rst_tie_dma_gnt", dma_gnt, 1'b0);
    cpu_req = 0; dma_req = 0;
    for (int i = 0; i < 6; i++) tick();

    // Request withdrawn after grant
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0002;
    tick();
    cpu_req = 0;
    cs = mem_cs ? 1 : 0;
    acks = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (mem_cs) cs++;
      if (cpu_ack) acks++;
    end
    chk("wd_cs_cycles", cs, WS + 1);
    chk("wd_acks", acks, 1);
    chk("wd_idle_cs", mem_cs, 1'b0);
    chk("wd_idle_gnt", {cpu_gnt, dma_gnt}, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
